ls_mem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the load path (loads whose address has been generated by the load/store FU) and the store-commit path (retiring stores drained from the store queue).
- Issues one command per cycle and tracks at most one outstanding load by memory tag.
- Returns load data to the LSQ, and discards the returned data of loads squashed on branch mispredict.
- Sits between the LSQ and the memory/dcache port.

---
 rtl/ls_mem_arbiter_if.sv | 56 +++++
 rtl/ls_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_ls_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_mem_arbiter_if.sv
// Bundle between the LSQ, the arbiter and the data-memory port.
// The arbiter takes the slave view; the LSQ/memory side takes master.
interface ls_mem_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             squash;
    logic             ld_req_valid;
    logic [XLEN-1:0]  ld_req_addr;
    logic [1:0]       ld_req_size;
    logic             ld_req_ready;
    logic             st_req_valid;
    logic [XLEN-1:0]  st_req_addr;
    logic [XLEN-1:0]  st_req_data;
    logic [1:0]       st_req_size;
    logic             st_urgent;
    logic             st_req_ready;
    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [XLEN-1:0]  proc2mem_data;
    logic [1:0]       proc2mem_size;
    logic [TAG_W-1:0] mem2proc_response;
    logic [TAG_W-1:0] mem2proc_tag;
    logic [XLEN-1:0]  mem2proc_data;
    logic             ld_done_valid;
    logic [XLEN-1:0]  ld_done_data;
    logic             busy;

    modport slave (
        input  squash,
        input  ld_req_valid, ld_req_addr, ld_req_size,
        output ld_req_ready,
        input  st_req_valid, st_req_addr, st_req_data, st_req_size,
        input  st_urgent,
        output st_req_ready,
        output proc2mem_command, proc2mem_addr,
        output proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output ld_done_valid, ld_done_data,
        output busy
    );

    modport master (
        output squash,
        output ld_req_valid, ld_req_addr, ld_req_size,
        input  ld_req_ready,
        output st_req_valid, st_req_addr, st_req_data, st_req_size,
        output st_urgent,
        input  st_req_ready,
        input  proc2mem_command, proc2mem_addr,
        input  proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  ld_done_valid, ld_done_data,
        input  busy
    );
endinterface

// File: rtl/ls_mem_arbiter.sv
// Load/store arbiter for the single data-memory port.
// One command per cycle, at most one tagged load in flight.
module ls_mem_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input logic              clock,
    input logic              reset_n,
    ls_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        LD_DRAIN
    } state_t;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             last_st_q, last_st_d;
    logic             done_v_q, done_v_d;
    logic [XLEN-1:0]  done_data_q, done_data_d;

    logic ld_elig, st_elig;
    logic gnt_ld, gnt_st;
    logic accepted, tag_hit, new_hit;

    // Pick the winner; urgent stores first, else alternate on last grant.
    always_comb begin
        ld_elig = reset_n && (state_q == IDLE)
                  && bus.ld_req_valid && !bus.squash;
        st_elig = reset_n && bus.st_req_valid;
        gnt_st  = st_elig
                  && (!ld_elig || bus.st_urgent || !last_st_q);
        gnt_ld  = ld_elig && !gnt_st;
        accepted = (bus.mem2proc_response != '0);
        tag_hit  = (bus.mem2proc_tag != '0)
                   && (bus.mem2proc_tag == tag_q);
        new_hit  = (bus.mem2proc_tag == bus.mem2proc_response);
    end

    // Drive the memory command and the requester handshakes.
    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = 2'd0;
        unique case (1'b1)
            gnt_ld: begin
                bus.proc2mem_command = BUS_LOAD;
                bus.proc2mem_addr    = bus.ld_req_addr;
                bus.proc2mem_size    = bus.ld_req_size;
            end
            gnt_st: begin
                bus.proc2mem_command = BUS_STORE;
                bus.proc2mem_addr    = bus.st_req_addr;
                bus.proc2mem_data    = bus.st_req_data;
                bus.proc2mem_size    = bus.st_req_size;
            end
            default: ;
        endcase
        bus.ld_req_ready = gnt_ld && accepted;
        bus.st_req_ready = gnt_st && accepted;
    end

    // Next-state: load tag tracking, squash draining, completion pulse.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        last_st_d   = last_st_q;
        done_v_d    = 1'b0;
        done_data_d = done_data_q;
        if (accepted && (gnt_ld || gnt_st)) begin
            last_st_d = gnt_st;
        end
        unique case (state_q)
            IDLE: begin
                if (gnt_ld && accepted) begin
                    if (new_hit) begin
                        done_v_d    = 1'b1;
                        done_data_d = bus.mem2proc_data;
                    end else begin
                        state_d = LD_WAIT;
                        tag_d   = bus.mem2proc_response;
                    end
                end
            end
            LD_WAIT: begin
                if (tag_hit) begin
                    state_d = IDLE;
                    tag_d   = '0;
                    if (!bus.squash) begin
                        done_v_d    = 1'b1;
                        done_data_d = bus.mem2proc_data;
                    end
                end else if (bus.squash) begin
                    state_d = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (tag_hit) begin
                    state_d = IDLE;
                    tag_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tag_d   = '0;
            end
        endcase
    end

    // State and completion registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            last_st_q   <= 1'b1;
            done_v_q    <= 1'b0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            last_st_q   <= last_st_d;
            done_v_q    <= done_v_d;
            done_data_q <= done_data_d;
        end
    end

    assign bus.ld_done_valid = done_v_q;
    assign bus.ld_done_data  = done_data_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Bench for ls_mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model and a load-data scoreboard.
module tb_ls_mem_arbiter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ls_mem_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    ls_mem_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // stimulus values applied just after each rising edge
    logic        d_sq, d_ldv, d_stv, d_urg;
    logic [31:0] d_lda, d_sta, d_std, d_md;
    logic [1:0]  d_lds, d_sts;
    logic [3:0]  d_resp, d_tag;

    // reference model: one load may be in flight, possibly killed
    bit          m_out, m_kill, m_last_st;
    logic [3:0]  m_tag;
    bit          pend_v;
    logic [31:0] pend_d;
    int          cyc = 0;

    // memory-side model used during random traffic
    bit          rand_mem = 0;
    bit          mem_pv = 0;
    logic [3:0]  mem_tag;
    int          mem_due;
    logic [31:0] mem_data;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        bus.squash            = d_sq;
        bus.ld_req_valid      = d_ldv;
        bus.ld_req_addr       = d_lda;
        bus.ld_req_size       = d_lds;
        bus.st_req_valid      = d_stv;
        bus.st_req_addr       = d_sta;
        bus.st_req_data       = d_std;
        bus.st_req_size       = d_sts;
        bus.st_urgent         = d_urg;
        bus.mem2proc_response = d_resp;
        bus.mem2proc_tag      = d_tag;
        bus.mem2proc_data     = d_md;
    endtask

    task automatic clear_inputs();
        d_sq = 0; d_ldv = 0; d_stv = 0; d_urg = 0;
        d_lda = 0; d_sta = 0; d_std = 0; d_md = 0;
        d_lds = 0; d_sts = 0; d_resp = 0; d_tag = 0;
    endtask

    task automatic model_reset();
        m_out = 0; m_kill = 0; m_last_st = 1; m_tag = 0;
        pend_v = 0; mem_pv = 0;
        exp_q.delete();
    endtask

    // compare this cycle's outputs, then advance the model
    task automatic model_step();
        bit ld_ok, st_ok, g_ld, g_st, acc;
        logic [1:0] cmd;
        g_ld = 0;
        g_st = 0;
        ld_ok = !m_out && d_ldv && !d_sq;
        st_ok = d_stv;
        if (ld_ok && st_ok) begin
            if (d_urg || !m_last_st) g_st = 1;
            else g_ld = 1;
        end else begin
            g_ld = ld_ok;
            g_st = st_ok;
        end
        acc = (d_resp != 0);
        cmd = g_ld ? 2'd1 : (g_st ? 2'd2 : 2'd0);
        chk("command", bus.proc2mem_command, cmd);
        if (g_ld) begin
            chk("ld_addr", bus.proc2mem_addr, d_lda);
            chk("ld_size", bus.proc2mem_size, d_lds);
            chk("ld_data", bus.proc2mem_data, 0);
        end
        if (g_st) begin
            chk("st_addr", bus.proc2mem_addr, d_sta);
            chk("st_size", bus.proc2mem_size, d_sts);
            chk("st_data", bus.proc2mem_data, d_std);
        end
        chk("ld_req_ready", bus.ld_req_ready, g_ld && acc);
        chk("st_req_ready", bus.st_req_ready, g_st && acc);
        chk("busy", bus.busy, m_out);

        if (acc && (g_ld || g_st)) m_last_st = g_st;
        if (g_ld && acc) begin
            if (d_tag == d_resp) begin
                pend_v = 1;
                pend_d = d_md;
            end else begin
                m_out = 1;
                m_kill = 0;
                m_tag = d_resp;
                if (rand_mem) begin
                    mem_pv = 1;
                    mem_tag = d_resp;
                    mem_due = cyc + int'($urandom_range(1, 6));
                    mem_data = $urandom;
                end
            end
            d_ldv = 0;
        end else if (m_out) begin
            if (d_tag != 0 && d_tag == m_tag) begin
                if (!m_kill && !d_sq) begin
                    pend_v = 1;
                    pend_d = d_md;
                end
                m_out = 0;
            end else if (d_sq) begin
                m_kill = 1;
            end
        end
        if (g_st && acc) d_stv = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        if (pend_v) begin
            exp_q.push_back(pend_d);
            pend_v = 0;
        end
        cyc++;
        #1 apply();
        #1 model_step();
    endtask

    // scoreboard monitor: each pulse must match the oldest expected load
    initial begin
        forever begin
            logic [31:0] e;
            @(negedge clock);
            if (bus.ld_done_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("ld_done_valid_unexpected", bus.ld_done_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ld_done_data", bus.ld_done_data, e);
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                chk("ld_done_valid_missing", bus.ld_done_valid, 1);
            end
        end
    end

    task automatic rand_gen();
        bit imm;
        logic [3:0] r;
        imm = 0;
        if (d_sq && d_ldv && $urandom_range(0, 1) == 1) d_ldv = 0;
        if (!d_ldv && $urandom_range(0, 99) < 40) begin
            d_ldv = 1;
            d_lda = $urandom;
            d_lds = 2'($urandom_range(0, 3));
        end
        if (!d_stv && $urandom_range(0, 99) < 40) begin
            d_stv = 1;
            d_sta = $urandom;
            d_std = $urandom;
            d_sts = 2'($urandom_range(0, 3));
        end
        d_urg = ($urandom_range(0, 99) < 20);
        d_sq  = ($urandom_range(0, 99) < 8);
        d_md  = $urandom;
        d_tag = 0;
        if (mem_pv && cyc + 1 >= mem_due) begin
            d_tag = mem_tag;
            d_md = mem_data;
            mem_pv = 0;
        end else if ($urandom_range(0, 99) < 10) begin
            do r = 4'($urandom_range(1, 15));
            while (mem_pv && r == mem_tag);
            d_tag = r;
        end else if (!mem_pv && $urandom_range(0, 99) < 15) begin
            imm = 1;
        end
        if (!imm && $urandom_range(0, 99) < 25) begin
            d_resp = 0;
        end else begin
            do r = 4'($urandom_range(1, 15));
            while (r == d_tag || (mem_pv && r == mem_tag));
            d_resp = r;
            if (imm) d_tag = r;
        end
    endtask

    initial begin
        clear_inputs();
        apply();
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;

        // reset while a load (tag 3) is outstanding
        d_ldv = 1; d_lda = 32'h40; d_lds = 2; d_resp = 3;
        cycle();
        d_ldv = 1; d_lda = 32'h44; d_stv = 1; d_sta = 32'h80;
        d_std = 32'h11; d_sts = 2; d_resp = 0;
        cycle();
        #1 reset_n = 0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_command", bus.proc2mem_command, 0);
        chk("rst_addr", bus.proc2mem_addr, 0);
        chk("rst_data", bus.proc2mem_data, 0);
        chk("rst_ld_done", bus.ld_done_valid, 0);
        model_reset();
        clear_inputs();
        @(negedge clock);
        reset_n = 1;
        d_tag = 3; d_md = 32'h33;
        cycle();
        d_tag = 0;
        cycle();

        // plain load, data 3 cycles later
        d_ldv = 1; d_lda = 32'h100; d_lds = 2; d_resp = 5;
        cycle();
        d_resp = 0;
        cycle();
        cycle();
        d_tag = 5; d_md = 32'hDEADBEEF;
        cycle();
        d_tag = 0;
        cycle();
        cycle();

        // round robin: store first to set last_grant, then both
        d_stv = 1; d_sta = 32'h10; d_std = 32'hA; d_sts = 2; d_resp = 1;
        cycle();
        d_ldv = 1; d_lda = 32'h200; d_lds = 1;
        d_stv = 1; d_sta = 32'h300; d_std = 32'h1234; d_sts = 2;
        d_resp = 6;
        cycle();
        d_ldv = 1; d_lda = 32'h204; d_resp = 9;
        cycle();
        d_resp = 0; d_tag = 6; d_md = 32'h600D;
        cycle();
        d_ldv = 0; d_tag = 0;
        cycle();

        // urgent store beats a load even after a store grant
        d_ldv = 1; d_lda = 32'h400; d_lds = 0;
        d_stv = 1; d_sta = 32'h404; d_std = 32'h77; d_sts = 0;
        d_urg = 1; d_resp = 4;
        cycle();
        cycle();
        d_urg = 0; d_resp = 0; d_tag = 4; d_md = 32'h4444;
        cycle();
        d_tag = 0;
        cycle();

        // rejected twice, then accepted with tag 7
        d_ldv = 1; d_lda = 32'h500; d_lds = 3; d_resp = 0;
        cycle();
        cycle();
        d_resp = 7;
        cycle();
        d_resp = 0; d_tag = 7; d_md = 32'hCAFEF00D;
        cycle();
        d_tag = 0;
        cycle();

        // squashed load drains, then a new load is accepted
        d_ldv = 1; d_lda = 32'h600; d_lds = 2; d_resp = 2;
        cycle();
        d_resp = 0; d_sq = 1;
        cycle();
        d_sq = 0;
        cycle();
        d_tag = 2; d_md = 32'hBAD;
        cycle();
        d_tag = 0; d_ldv = 1; d_lda = 32'h604; d_resp = 8;
        cycle();
        d_resp = 0; d_tag = 8; d_md = 32'h8888;
        cycle();
        d_tag = 0;

        // same-cycle completion
        d_ldv = 1; d_lda = 32'h700; d_lds = 2;
        d_resp = 4'hA; d_tag = 4'hA; d_md = 32'h55AA;
        cycle();
        clear_inputs();
        cycle();
        cycle();

        // random traffic
        rand_mem = 1;
        for (int i = 0; i < 3000; i++) begin
            rand_gen();
            cycle();
        end
        d_ldv = 0; d_stv = 0; d_sq = 0;
        for (int i = 0; i < 20; i++) begin
            rand_gen();
            d_ldv = 0; d_stv = 0; d_sq = 0;
            cycle();
        end
        @(posedge clock);
        if (pend_v) begin
            exp_q.push_back(pend_d);
            pend_v = 0;
        end
        @(negedge clock);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
